mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM encoding, requester indices and default widths.
package mem_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between fetch and data.
// Each access takes three cycles: grant/latch, issue, response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  win_q, win_d;
    logic                  pick;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            done_q, done_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // Next state: arbitrate and latch in IDLE, pulse write in ISSUE, done in RESP.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        win_d   = win_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        pick    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    pick    = (req == 2'b11) ? prio_q : req[REQ_DATA];
                    win_d   = pick;
                    prio_d  = ~pick;
                    we_d    = req_we[pick];
                    addr_d  = pick ? req_addr1 : req_addr0;
                    din_d   = pick ? req_wdata1 : req_wdata0;
                    if (pick) begin
                        gnt_d[REQ_DATA] = 1'b1;
                    end else begin
                        gnt_d[REQ_FETCH] = 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (win_q) begin
                    done_d[REQ_DATA] = 1'b1;
                end else begin
                    done_d[REQ_FETCH] = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign rdata    = (done_q != 2'b00) ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a local 32x4 memory and a transaction model.
// Directed scenarios pin exact values; random traffic runs against the model.
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    req;
    logic [1:0]    req_we;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [DW-1:0] req_wdata0;
    logic [DW-1:0] req_wdata1;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic [DW-1:0] rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_wdata0(req_wdata0),
        .req_wdata1(req_wdata1),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] init_val(input int i);
        logic [DW-1:0] v;
        v = 4'((i * 7 + 3) % 16);
        if (i == 5) v = 4'hA;
        if (i == 9) v = 4'h2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Synchronous read-before-write memory the arbiter drives.
    logic [DW-1:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = init_val(i);
        mem_dout = '0;
        forever begin
            @(posedge clk);
            mem_dout <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_din;
        end
    end

    // Transaction model: expected outputs per cycle, in an 8-entry ring.
    logic [DW-1:0] ref_mem [32];
    logic [1:0]    eg [8];
    logic [1:0]    ed [8];
    logic [DW-1:0] er [8];
    logic          ew [8];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    int            cyc;
    int            next_free;
    int            prio;
    int            w;
    int            s0;
    int            s1;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          mw;

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 8; i++) begin
            eg[i] = 0; ed[i] = 0; er[i] = 0; ew[i] = 0;
        end
        exp_addr = 0; exp_din = 0; cyc = 0; next_free = 0; prio = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) begin
                    eg[i] = 0; ed[i] = 0; er[i] = 0; ew[i] = 0;
                end
                exp_addr = 0; exp_din = 0;
                cyc = 0; next_free = 0; prio = 0;
            end else begin
                cyc++;
                s0 = cyc % 8;
                s1 = (cyc + 1) % 8;
                eg[s1] = 0; ed[s1] = 0; er[s1] = 0; ew[s1] = 0;
                if (cyc >= next_free && req != 2'b00) begin
                    w = (req == 2'b11) ? prio : (req[1] ? 1 : 0);
                    prio = 1 - w;
                    ma = (w == 1) ? req_addr1 : req_addr0;
                    md = (w == 1) ? req_wdata1 : req_wdata0;
                    mw = req_we[w];
                    eg[s0] = 2'(1 << w);
                    ew[s0] = mw;
                    exp_addr = ma;
                    exp_din = md;
                    ed[s1] = 2'(1 << w);
                    er[s1] = ref_mem[ma];
                    if (mw) ref_mem[ma] = md;
                    next_free = cyc + 3;
                end
            end
        end
    end

    // Every cycle: compare all outputs with the model (zeros under reset).
    int idx;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_gnt", 32'(gnt), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_rdata", 32'(rdata), 0);
                chk("rst_mem_we", 32'(mem_we), 0);
                chk("rst_mem_addr", 32'(mem_addr), 0);
                chk("rst_mem_din", 32'(mem_din), 0);
            end else begin
                idx = cyc % 8;
                chk("gnt", 32'(gnt), 32'(eg[idx]));
                chk("done", 32'(done), 32'(ed[idx]));
                chk("rdata", 32'(rdata),
                    32'((ed[idx] != 2'b00) ? er[idx] : 4'h0));
                chk("mem_we", 32'(mem_we), 32'(ew[idx]));
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                chk("mem_din", 32'(mem_din), 32'(exp_din));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        req = 2'b00;
        req_we = 2'b00;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic do_txn(input int id, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [1:0] g, output logic [1:0] dn,
                          output logic [DW-1:0] r);
        req = 2'(1 << id);
        req_we = we ? req : 2'b00;
        if (id == 1) begin
            req_addr1 = a; req_wdata1 = d;
        end else begin
            req_addr0 = a; req_wdata0 = d;
        end
        @(negedge clk);
        g = gnt;
        req = 2'b00;
        req_we = 2'b00;
        @(negedge clk);
        dn = done;
        r = rdata;
        @(negedge clk);
    endtask

    logic [1:0]    tg;
    logic [1:0]    td;
    logic [DW-1:0] tr;
    int            eg_c;

    initial begin
        req = 0; req_we = 0;
        req_addr0 = 0; req_addr1 = 0;
        req_wdata0 = 0; req_wdata1 = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_mem_addr", 32'(mem_addr), 0);
        #2 rst_n = 1'b1;

        do_txn(0, 1'b0, 5'd5, 4'h0, tg, td, tr);
        chk("read_gnt", 32'(tg), 1);
        chk("read_done", 32'(td), 1);
        chk("read_rdata", 32'(tr), 'hA);

        do_txn(1, 1'b1, 5'd3, 4'h7, tg, td, tr);
        chk("wr3_gnt", 32'(tg), 2);
        chk("wr3_done", 32'(td), 2);
        chk("wr3_old", 32'(tr), 'h8);
        do_txn(1, 1'b0, 5'd3, 4'h0, tg, td, tr);
        chk("rd3_rdata", 32'(tr), 'h7);

        do_txn(1, 1'b1, 5'd9, 4'hF, tg, td, tr);
        chk("rbw9_old", 32'(tr), 'h2);
        do_txn(0, 1'b0, 5'd9, 4'h0, tg, td, tr);
        chk("rd9_done", 32'(td), 1);
        chk("rd9_new", 32'(tr), 'hF);

        do_reset();
        req = 2'b11; req_we = 2'b00;
        req_addr0 = 5'd1; req_addr1 = 5'd2;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            eg_c = (k % 3 != 1) ? 0 : (((k / 3) % 2 == 1) ? 2 : 1);
            chk($sformatf("rr_gnt_%0d", k), 32'(gnt), eg_c);
        end
        req = 2'b00;
        repeat (2) @(negedge clk);

        req = 2'b01; req_we = 2'b00; req_addr0 = 5'd5;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 1);
        #2 rst_n = 1'b0;
        req = 2'b00;
        #1;
        chk("abort_async_gnt", 32'(gnt), 0);
        chk("abort_async_addr", 32'(mem_addr), 0);
        chk("abort_async_done", 32'(done), 0);
        @(negedge clk);
        chk("abort_done_a", 32'(done), 0);
        @(negedge clk);
        chk("abort_done_b", 32'(done), 0);
        #2 rst_n = 1'b1;
        req = 2'b11;
        @(negedge clk);
        chk("post_abort_gnt", 32'(gnt), 1);
        req = 2'b00;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_sig", {29'd0, mem_we, gnt}, 0);
            chk("idle_done", 32'(done), 0);
        end

        repeat (400) begin
            req = 2'($urandom_range(0, 3));
            req_we = ($urandom_range(0, 2) == 0) ?
                     2'($urandom_range(0, 3)) : 2'b00;
            req_addr0 = 5'($urandom_range(0, 31));
            req_addr1 = 5'($urandom_range(0, 31));
            req_wdata0 = 4'($urandom_range(0, 15));
            req_wdata1 = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        req = 2'b00;
        req_we = 2'b00;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
